// File: rtl/uart_axil_regs.sv
// AXI4-Lite register block for the UART parallel side: TX/RX byte handshakes,
// sticky error flags, prescale/interrupt-enable control and a level interrupt.
module uart_axil_regs #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [31:0]           s_axil_wdata,
    input  logic [3:0]            s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [31:0]           s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,

    output logic [DATA_WIDTH-1:0] uart_tx_data,
    output logic                  uart_tx_start,
    input  logic                  uart_tx_busy,
    input  logic [DATA_WIDTH-1:0] uart_rx_data,
    input  logic                  uart_rx_ready,
    output logic                  uart_rx_ack,
    input  logic                  uart_rx_overrun,
    input  logic                  uart_rx_framing,
    output logic [15:0]           uart_prescale,
    output logic                  irq
);

    localparam logic [1:0] SEL_TXDATA = 2'd0;
    localparam logic [1:0] SEL_RXDATA = 2'd1;
    localparam logic [1:0] SEL_STATUS = 2'd2;
    localparam logic [1:0] SEL_CTRL   = 2'd3;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    w_state_t              w_state;
    r_state_t              r_state;

    logic                  aw_held;
    logic                  w_held;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [31:0]           w_data_q;
    logic [3:0]            w_strb_q;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  ar_hs;
    logic                  wr_fire;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]           wr_data;
    logic [3:0]            wr_strb;
    logic [1:0]            wr_sel;
    logic [1:0]            rd_sel;

    logic [17:0]           ctrl_q;
    logic                  rx_ie;
    logic                  tx_ie;
    logic [DATA_WIDTH-1:0] tx_hold;
    logic                  tx_pending;
    logic                  tx_guard;
    logic                  tx_active;
    logic                  start_cond;
    logic                  tx_write;
    logic                  tx_accept;
    logic                  tx_drop;
    logic                  overrun_sticky;
    logic                  framing_sticky;
    logic                  tx_overflow_sticky;
    logic [2:0]            w1c_mask;
    logic                  rx_guard;
    logic                  ack_cond;
    logic [31:0]           rd_value;
    logic                  unused_bits;

    assign s_axil_bresp  = 2'b00;
    assign s_axil_rresp  = 2'b00;
    assign uart_prescale = ctrl_q[15:0];
    assign rx_ie         = ctrl_q[16];
    assign tx_ie         = ctrl_q[17];
    assign unused_bits   = ^{wr_addr, wr_data[31:18], wr_strb[3], s_axil_araddr};

    // AW and W may arrive in either order; the held copy takes priority over the live bus.
    always_comb begin
        aw_hs      = s_axil_awvalid & s_axil_awready;
        w_hs       = s_axil_wvalid & s_axil_wready;
        ar_hs      = s_axil_arvalid & s_axil_arready;
        wr_addr    = aw_held ? aw_addr_q : s_axil_awaddr;
        wr_data    = w_held ? w_data_q : s_axil_wdata;
        wr_strb    = w_held ? w_strb_q : s_axil_wstrb;
        wr_sel     = wr_addr[3:2];
        rd_sel     = s_axil_araddr[3:2];
        wr_fire    = (w_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);
        tx_active  = tx_pending | uart_tx_busy;
        // Guarding on the pulse itself and the cycle after covers a UART whose busy lags start.
        start_cond = tx_pending & ~uart_tx_busy & ~tx_guard & ~uart_tx_start;
        tx_write   = wr_fire && (wr_sel == SEL_TXDATA) && wr_strb[0];
        tx_accept  = tx_write && (!tx_pending || start_cond);
        tx_drop    = tx_write && tx_pending && !start_cond;
        w1c_mask   = (wr_fire && (wr_sel == SEL_STATUS) && wr_strb[0]) ? wr_data[4:2] : 3'b000;
        ack_cond   = ar_hs && (rd_sel == SEL_RXDATA) && uart_rx_ready && !rx_guard && !uart_rx_ack;
    end

    always_comb begin
        rd_value = '0;
        case (rd_sel)
            SEL_RXDATA: begin
                rd_value[DATA_WIDTH-1:0] = uart_rx_data;
                rd_value[31]             = uart_rx_ready;
            end
            SEL_STATUS: rd_value[4:0] = {tx_overflow_sticky, framing_sticky, overrun_sticky,
                                         tx_active, uart_rx_ready};
            SEL_CTRL:   rd_value[17:0] = ctrl_q;
            default:    rd_value = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state        <= W_IDLE;
            s_axil_awready <= 1'b0;
            s_axil_wready  <= 1'b0;
            s_axil_bvalid  <= 1'b0;
            aw_held        <= 1'b0;
            w_held         <= 1'b0;
            aw_addr_q      <= '0;
            w_data_q       <= '0;
            w_strb_q       <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_held   <= 1'b1;
                        aw_addr_q <= s_axil_awaddr;
                    end
                    if (w_hs) begin
                        w_held   <= 1'b1;
                        w_data_q <= s_axil_wdata;
                        w_strb_q <= s_axil_wstrb;
                    end
                    if (wr_fire) begin
                        w_state        <= W_RESP;
                        s_axil_bvalid  <= 1'b1;
                        s_axil_awready <= 1'b0;
                        s_axil_wready  <= 1'b0;
                    end else begin
                        s_axil_awready <= !(aw_held || aw_hs);
                        s_axil_wready  <= !(w_held || w_hs);
                    end
                end
                W_RESP: begin
                    if (s_axil_bready) begin
                        w_state        <= W_IDLE;
                        s_axil_bvalid  <= 1'b0;
                        aw_held        <= 1'b0;
                        w_held         <= 1'b0;
                        s_axil_awready <= 1'b1;
                        s_axil_wready  <= 1'b1;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= R_IDLE;
            s_axil_arready <= 1'b0;
            s_axil_rvalid  <= 1'b0;
            s_axil_rdata   <= '0;
            uart_rx_ack    <= 1'b0;
            rx_guard       <= 1'b0;
        end else begin
            uart_rx_ack <= ack_cond;
            rx_guard    <= uart_rx_ack;
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_state        <= R_RESP;
                        s_axil_rdata   <= rd_value;
                        s_axil_rvalid  <= 1'b1;
                        s_axil_arready <= 1'b0;
                    end else begin
                        s_axil_arready <= 1'b1;
                    end
                end
                R_RESP: begin
                    if (s_axil_rready) begin
                        r_state        <= R_IDLE;
                        s_axil_rvalid  <= 1'b0;
                        s_axil_arready <= 1'b1;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // uart_tx_data gets its own copy so a refill during the start pulse cannot disturb it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            uart_tx_start      <= 1'b0;
            uart_tx_data       <= '0;
            tx_hold            <= '0;
            tx_pending         <= 1'b0;
            tx_guard           <= 1'b0;
            overrun_sticky     <= 1'b0;
            framing_sticky     <= 1'b0;
            tx_overflow_sticky <= 1'b0;
            irq                <= 1'b0;
        end else begin
            uart_tx_start <= start_cond;
            tx_guard      <= uart_tx_start;
            if (start_cond) begin
                uart_tx_data <= tx_hold;
            end
            if (tx_accept) begin
                tx_hold    <= wr_data[DATA_WIDTH-1:0];
                tx_pending <= 1'b1;
            end else if (start_cond) begin
                tx_pending <= 1'b0;
            end
            overrun_sticky     <= uart_rx_overrun | (overrun_sticky & ~w1c_mask[0]);
            framing_sticky     <= uart_rx_framing | (framing_sticky & ~w1c_mask[1]);
            tx_overflow_sticky <= tx_drop | (tx_overflow_sticky & ~w1c_mask[2]);
            irq <= (rx_ie & uart_rx_ready) | (tx_ie & ~tx_active) |
                   (rx_ie & (overrun_sticky | framing_sticky));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q <= '0;
        end else if (wr_fire && (wr_sel == SEL_CTRL)) begin
            if (wr_strb[0]) ctrl_q[7:0]   <= wr_data[7:0];
            if (wr_strb[1]) ctrl_q[15:8]  <= wr_data[15:8];
            if (wr_strb[2]) ctrl_q[17:16] <= wr_data[17:16];
        end
    end

endmodule
